// File: rtl/dmem_dump_reader.sv
// Streams a contiguous byte range out of the data RAM over valid/ready.
// Pipelined reads with credit flow control into a small output FIFO.
module dmem_dump_reader #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 16,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [LEN_W-1:0]    sent_q, sent_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rden_q, mem_rden_d;
  logic [RD_LAT-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic                push;
  logic                pop;
  logic                issue;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       reserved;
  logic [CW-1:0]       limit;

  assign mem_addr  = mem_addr_q;
  assign mem_rden  = mem_rden_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);

  // Outstanding reads: the registered strobe plus every live return tag.
  always_comb begin
    inflight = CW'(mem_rden_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(tag_q[i]);
    end
  end

  // Credit check, a slot freed by this cycle's pop counts as available.
  always_comb begin
    push     = tag_q[RD_LAT-1];
    pop      = out_valid & out_ready;
    reserved = CW'(count_q) + inflight;
    limit    = CW'(FIFO_DEPTH) + CW'(pop);
    issue    = (state_q == RUN) &&
               (issued_q < len_q) &&
               (reserved < limit);
  end

  // Next-state: FSM, read issue, tag shift, FIFO bookkeeping, abort flush.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    mem_addr_d = mem_addr_q;
    mem_rden_d = 1'b0;
    tag_d      = (tag_q << 1) | RD_LAT'(mem_rden_q);
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          base_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          sent_d   = '0;
          state_d  = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          mem_rden_d = 1'b1;
          mem_addr_d = base_q + ADDR_W'(issued_q);
          issued_d   = issued_q + LEN_W'(1);
        end
        if (pop) begin
          sent_d = sent_q + LEN_W'(1);
          if (sent_q + LEN_W'(1) == len_q) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = mem_q;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    if (abort) begin
      state_d    = IDLE;
      mem_rden_d = 1'b0;
      tag_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      mem_addr_q <= '0;
      mem_rden_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      mem_addr_q <= mem_addr_d;
      mem_rden_q <= mem_rden_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_dmem_dump_reader.sv
// Bench for dmem_dump_reader: RAM model, stream scoreboard,
// table vectors, random dumps and abort/reset corner sequences.
module tb_dmem_dump_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic [15:0] mem_addr;
  logic        mem_rden;
  logic [7:0]  mem_q;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [7:0]  ram [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          mode;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rden) mem_q <= ram[mem_addr];
  end

  dmem_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .length    (length),
    .mem_addr  (mem_addr),
    .mem_rden  (mem_rden),
    .mem_q     (mem_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reset held for two cycles with start asserted.
  task automatic do_reset();
    reset = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    base_addr = 16'h1234;
    length = 16'd5;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_addr", mem_addr, 0);
      check("rst_rden", mem_rden, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 ready, 1 random, 2 toggle, 3 stalled 12 cycles.
  // kill: 0 none, 1 abort, 2 reset, applied after 3 beats.
  task automatic run_dump(input logic [15:0] b,
                          input logic [15:0] n,
                          input int mode,
                          input int lat,
                          input int kill);
    int k, reads, beats, dones, budget;
    int first_rd, last_rd, first_v, last_beat, done_k;
    logic held, post, rdy;
    logic [7:0] hval;
    logic [15:0] a;
    k = 0; reads = 0; beats = 0; dones = 0;
    first_rd = -1; last_rd = -1;
    first_v = -1; last_beat = -1; done_k = -1;
    held = 1'b0; post = 1'b0; hval = '0;
    budget = 20 * int'(n) + 40;
    base_addr = b;
    length = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    forever begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 9) < 7);
        2: rdy = k[0];
        3: rdy = (k >= 12);
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
      @(negedge clk);
      if (mem_rden) begin
        a = b + reads[15:0];
        check("rd_addr", mem_addr, a);
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        reads++;
      end
      if (mode == 3 && k == 11) begin
        check("bp_reads", reads, 4);
        check("bp_rden", mem_rden, 0);
        check("bp_valid", out_valid, 1);
        check("bp_first", out_data, ram[b]);
      end
      if (out_valid) begin
        if (first_v < 0) first_v = k;
        if (held) check("hold", out_data, hval);
        if (rdy) begin
          a = b + beats[15:0];
          check("data", out_data, ram[a]);
          beats++;
          last_beat = k;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hval = out_data;
        end
      end
      if (post) begin
        check("done_once", done, 0);
        check("busy_after", busy, 0);
        break;
      end
      if (done) begin
        dones++;
        done_k = k;
        post = 1'b1;
        check("done_after_last", beats, n);
        check("busy_in_fin", busy, 0);
      end
      if (kill != 0 && beats == 3) begin
        @(posedge clk);
        #1;
        if (kill == 1) abort = 1'b1;
        else reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("kill_valid", out_valid, 0);
          check("kill_busy", busy, 0);
          check("kill_done", done, 0);
          check("kill_rden", mem_rden, 0);
          @(posedge clk);
          #1;
        end
        return;
      end
      if (k >= budget) begin
        check("timeout", 0, 1);
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
    check("beats", beats, n);
    check("reads", reads, n);
    check("dones", dones, 1);
    if (n == 0) check("zero_done_k", done_k, 0);
    if (lat > 0) begin
      check("first_rd", first_rd, 1);
      check("first_valid", first_v, lat);
      check("rd_rate", last_rd - first_rd, int'(n) - 1);
      check("out_rate", last_beat - first_v, int'(n) - 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    ram[16'h0010] = 8'hA0;
    ram[16'h0011] = 8'hA1;
    ram[16'h0012] = 8'hA2;
    ram[16'h0013] = 8'hA3;

    tbl[0] = '{base: 16'h0010, len: 16'd4,  mode: 0, lat: 3};
    tbl[1] = '{base: 16'hFFFE, len: 16'd4,  mode: 0, lat: 3};
    tbl[2] = '{base: 16'h0000, len: 16'd0,  mode: 0, lat: 0};
    tbl[3] = '{base: 16'h0100, len: 16'd10, mode: 3, lat: 0};
    tbl[4] = '{base: 16'h0200, len: 16'd16, mode: 1, lat: 0};
    tbl[5] = '{base: 16'hFFF0, len: 16'd20, mode: 2, lat: 0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_dump(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].lat, 0);
    end

    for (int i = 0; i < 6; i++) begin
      run_dump(16'($urandom), 16'($urandom_range(1, 24)), 1, 0, 0);
    end

    run_dump(16'h0040, 16'd8, 2, 0, 1);
    run_dump(16'h0020, 16'd2, 0, 3, 0);

    run_dump(16'h0060, 16'd8, 2, 0, 2);
    run_dump(16'h0020, 16'd2, 0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
